// File: rtl/softmax_sequencer.sv
// softmax_sequencer: buffers one softmax vector, tracks its maximum, then replays it to the exp pass and the output pass.
module softmax_sequencer #(
  parameter int DATA_SIZE      = 32,
  parameter int NUMBER_OF_DATA = 10,
  parameter int ADDR_SIZE      = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 exp_valid_o,
  input  logic                 exp_ready_i,
  output logic [DATA_SIZE-1:0] exp_x_o,
  output logic [DATA_SIZE-1:0] exp_max_o,
  output logic                 exp_last_o,
  input  logic                 ln_valid_i,
  input  logic [DATA_SIZE-1:0] ln_sum_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_SIZE-1:0] out_x_o,
  output logic [DATA_SIZE-1:0] out_max_o,
  output logic [DATA_SIZE-1:0] out_ln_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o
);
  typedef enum logic [2:0] {IDLE, LOAD, EXP, WAIT_LN, OUT} state_t;
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(NUMBER_OF_DATA - 1);
  localparam logic [ADDR_SIZE-1:0] ONE  = ADDR_SIZE'(1);
  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic [DATA_SIZE-1:0] max_q, max_d, ln_q, ln_d;
  logic [DATA_SIZE-1:0] buf_q [NUMBER_OF_DATA];
  logic                 buf_we;
  logic                 exp_valid_q, exp_valid_d, exp_last_q, exp_last_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_SIZE-1:0] exp_x_q, exp_x_d, exp_max_q, exp_max_d;
  logic [DATA_SIZE-1:0] out_x_q, out_x_d, out_max_q, out_max_d;
  logic                 done_q, done_d;
  // Raw-bit float compare: +0 and -0 tie, negatives order by reversed magnitude.
  function automatic logic gt(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
    return (a[DATA_SIZE-1] != b[DATA_SIZE-1])
      ? (!a[DATA_SIZE-1] && (a[DATA_SIZE-2:0] != '0 || b[DATA_SIZE-2:0] != '0))
      : (a[DATA_SIZE-1] ? (a < b) : (a > b));
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    ln_d    = ln_q;
    buf_we  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        buf_we  = 1'b1;
        max_d   = data_i;
        idx_d   = ONE;
        state_d = LOAD;
      end
      LOAD: begin
        buf_we  = 1'b1;
        max_d   = gt(data_i, max_q) ? data_i : max_q;
        idx_d   = (idx_q == LAST) ? '0 : idx_q + ONE;
        state_d = (idx_q == LAST) ? EXP : LOAD;
      end
      EXP: if (exp_ready_i) begin
        idx_d   = (idx_q == LAST) ? '0 : idx_q + ONE;
        state_d = (idx_q == LAST) ? WAIT_LN : EXP;
      end
      WAIT_LN: if (ln_valid_i) begin
        ln_d    = ln_sum_i;
        state_d = OUT;
      end
      OUT: if (out_ready_i) begin
        idx_d   = (idx_q == LAST) ? '0 : idx_q + ONE;
        state_d = (idx_q == LAST) ? IDLE : OUT;
        done_d  = (idx_q == LAST);
      end
      default: state_d = IDLE;
    endcase
    // Output registers load from the next index so a beat is presented the cycle its state begins.
    exp_valid_d = (state_d == EXP);
    exp_last_d  = exp_valid_d && (idx_d == LAST);
    exp_x_d     = exp_valid_d ? buf_q[idx_d] : exp_x_q;
    exp_max_d   = exp_valid_d ? max_d : exp_max_q;
    out_valid_d = (state_d == OUT);
    out_last_d  = out_valid_d && (idx_d == LAST);
    out_x_d     = out_valid_d ? buf_q[idx_d] : out_x_q;
    out_max_d   = out_valid_d ? max_d : out_max_q;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      max_q       <= '0;
      ln_q        <= '0;
      exp_valid_q <= 1'b0;
      exp_last_q  <= 1'b0;
      exp_x_q     <= '0;
      exp_max_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_max_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      ln_q        <= ln_d;
      exp_valid_q <= exp_valid_d;
      exp_last_q  <= exp_last_d;
      exp_x_q     <= exp_x_d;
      exp_max_q   <= exp_max_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_x_q     <= out_x_d;
      out_max_q   <= out_max_d;
      done_q      <= done_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (buf_we) buf_q[idx_q] <= data_i;
  end
  assign exp_valid_o = exp_valid_q;
  assign exp_last_o  = exp_last_q;
  assign exp_x_o     = exp_x_q;
  assign exp_max_o   = exp_max_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_x_o     = out_x_q;
  assign out_max_o   = out_max_q;
  assign out_ln_o    = ln_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
endmodule

// File: tb/tb_softmax_sequencer.sv
// tb_softmax_sequencer: directed vectors with hand-computed maxima, ln values and cycle counts.
module tb_softmax_sequencer;
  logic        clock_i = 1'b0, reset_i = 1'b1, start_i = 1'b0;
  logic [31:0] data_i = '0, ln_sum_i = '0;
  logic        exp_ready_i = 1'b1, out_ready_i = 1'b1, ln_valid_i = 1'b0;
  logic        exp_valid_o, exp_last_o, out_valid_o, out_last_o, busy_o, done_o;
  logic [31:0] exp_x_o, exp_max_o, out_x_o, out_max_o, out_ln_o;
  int          checks = 0, failures = 0, cyc = 0, s_cyc = 0, d_cyc = 0, done_cnt = 0;
  bit          bp = 1'b0;
  logic [3:0]  pat = 4'b0110;
  logic [31:0] ex_q[$], em_q[$], ox_q[$], om_q[$], ol_q[$];
  logic        el_q[$], ot_q[$];
  logic        e_st = 1'b0, o_st = 1'b0, e_sl, o_sl;
  logic [31:0] e_sx, o_sx;
  logic [31:0] v_nom [10] = '{32'hC05060D2, 32'h40A5D0A4, 32'hBF3A1674, 32'h401D24F6, 32'hBE3BD70A,
                              32'h3F461F7D, 32'hC0350DF4, 32'h40BEEE67, 32'hC0A6D2C4, 32'h3F9DF3B6};
  logic [31:0] v_neg [10] = '{32'hC0A00000, 32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000,
                              32'hC1200000, 32'hBFC00000, 32'hC1000000, 32'hC0C00000, 32'hC0E00000};
  logic [31:0] v_zero[10] = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000,
                              32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000};
  logic [31:0] v_w   [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

  softmax_sequencer dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .data_i(data_i),
    .exp_valid_o(exp_valid_o), .exp_ready_i(exp_ready_i), .exp_x_o(exp_x_o),
    .exp_max_o(exp_max_o), .exp_last_o(exp_last_o), .ln_valid_i(ln_valid_i),
    .ln_sum_i(ln_sum_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_x_o(out_x_o), .out_max_o(out_max_o), .out_ln_o(out_ln_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({exp_valid_o, exp_last_o, out_valid_o, out_last_o, busy_o, done_o}), 0);
    chk({tag, "_exp_x"}, exp_x_o, 0);
    chk({tag, "_exp_max"}, exp_max_o, 0);
    chk({tag, "_out_x"}, out_x_o, 0);
    chk({tag, "_out_max"}, out_max_o, 0);
    chk({tag, "_out_ln"}, out_ln_o, 0);
  endtask

  task automatic clear();
    ex_q.delete(); em_q.delete(); el_q.delete();
    ox_q.delete(); om_q.delete(); ol_q.delete(); ot_q.delete();
    done_cnt = 0;
  endtask

  initial forever begin
    @(posedge clock_i); #1;
    exp_ready_i = bp ? pat[cyc % 4] : 1'b1;
    out_ready_i = bp ? pat[cyc % 4] : 1'b1;
  end

  // Handshake monitor: records accepted beats and checks stalled beats stay put.
  always @(negedge clock_i) begin
    if (e_st) begin
      chk("exp_hold_valid", 32'(exp_valid_o), 1);
      chk("exp_hold_x", exp_x_o, e_sx);
      chk("exp_hold_last", 32'(exp_last_o), 32'(e_sl));
    end
    if (o_st) begin
      chk("out_hold_valid", 32'(out_valid_o), 1);
      chk("out_hold_x", out_x_o, o_sx);
      chk("out_hold_last", 32'(out_last_o), 32'(o_sl));
    end
    if (exp_valid_o && exp_ready_i) begin
      ex_q.push_back(exp_x_o); em_q.push_back(exp_max_o); el_q.push_back(exp_last_o);
    end
    if (out_valid_o && out_ready_i) begin
      ox_q.push_back(out_x_o); om_q.push_back(out_max_o); ol_q.push_back(out_ln_o); ot_q.push_back(out_last_o);
    end
    e_st = exp_valid_o && !exp_ready_i; e_sx = exp_x_o; e_sl = exp_last_o;
    o_st = out_valid_o && !out_ready_i; o_sx = out_x_o; o_sl = out_last_o;
    if (done_o) begin
      done_cnt++;
      d_cyc = cyc;
      chk("done_busy_low", 32'(busy_o), 0);
    end
  end

  task automatic feed(input logic [31:0] v[10], input bit hold, input logic [31:0] nxt);
    clear();
    @(posedge clock_i); #1;
    chk("busy_before_start", 32'(busy_o), 0);
    start_i = 1'b1; data_i = v[0]; s_cyc = cyc;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock_i); #1;
      start_i = hold; data_i = v[i];
      if (i == 1) chk("busy_rise", 32'(busy_o), 1);
      if (i == 9) chk("load_no_exp_valid", 32'(exp_valid_o), 0);
    end
    @(posedge clock_i); #1;
    start_i = hold; data_i = nxt;
  endtask

  task automatic feed_rest(input logic [31:0] w[10]);
    for (int i = 1; i < 10; i++) begin
      @(posedge clock_i); #1;
      start_i = 1'b0; data_i = w[i];
    end
    @(posedge clock_i); #1;
    data_i = '0;
  endtask

  task automatic fin(input logic [31:0] v[10], input logic [31:0] emax, input logic [31:0] lnv,
                     input bit pulse, input int dly, input bit hold, input bit tm);
    int n;
    bit pulsed;
    n = 0; pulsed = 1'b0;
    while (ex_q.size() < 10 && n < 200) begin
      @(posedge clock_i); #1;
      n++;
      if (pulse && !pulsed && ex_q.size() == 2) begin
        ln_valid_i = 1'b1; ln_sum_i = 32'hDEADBEEF; pulsed = 1'b1;
      end else begin
        ln_valid_i = 1'b0;
      end
    end
    chk("exp_beats", ex_q.size(), 10);
    chk("wait_ln_exp_valid", 32'(exp_valid_o), 0);
    chk("wait_ln_busy", 32'(busy_o), 1);
    for (int k = 0; k < dly; k++) begin
      chk("wait_ln_out_valid", 32'(out_valid_o), 0);
      @(posedge clock_i); #1;
    end
    ln_valid_i = 1'b1; ln_sum_i = lnv;
    @(posedge clock_i); #1;
    ln_valid_i = 1'b0; ln_sum_i = 32'h12345678;
    chk("out_valid_rise", 32'(out_valid_o), 1);
    chk("out_ln_latched", out_ln_o, lnv);
    n = 0;
    while (!done_o && n < 200) begin
      @(posedge clock_i); #1;
      n++;
    end
    chk("done_seen", 32'(done_o), 1);
    @(negedge clock_i); #1;
    chk("exp_count", ex_q.size(), 10);
    chk("out_count", ox_q.size(), 10);
    for (int i = 0; i < 10 && i < ex_q.size() && i < ox_q.size(); i++) begin
      chk("exp_x", ex_q[i], v[i]);
      chk("exp_max", em_q[i], emax);
      chk("exp_last", 32'(el_q[i]), 32'(i == 9));
      chk("out_x", ox_q[i], v[i]);
      chk("out_max", om_q[i], emax);
      chk("out_ln", ol_q[i], lnv);
      chk("out_last", 32'(ot_q[i]), 32'(i == 9));
    end
    chk("done_once", done_cnt, 1);
    if (tm) chk("latency", d_cyc - s_cyc, 31);
    if (!hold) begin
      @(posedge clock_i); #1;
      chk("done_pulse_end", 32'(done_o), 0);
      chk("idle_busy", 32'(busy_o), 0);
      chk("idle_no_start", 32'(exp_valid_o | out_valid_o), 0);
    end
    clear();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock_i);
    #1;
    chk_zero("reset");
    reset_i = 1'b0;
    feed(v_nom, 1'b0, '0);
    fin(v_nom, 32'h40BEEE67, 32'h40C00000, 1'b1, 0, 1'b0, 1'b1);
    bp = 1'b1;
    feed(v_neg, 1'b0, '0);
    fin(v_neg, 32'hBF800000, 32'h3F000000, 1'b0, 2, 1'b0, 1'b0);
    feed(v_zero, 1'b0, '0);
    fin(v_zero, 32'h80000000, 32'h3F800000, 1'b1, 1, 1'b0, 1'b0);
    bp = 1'b0;
    feed(v_nom, 1'b0, '0);
    n = 0;
    while (ex_q.size() < 4 && n < 100) begin
      @(posedge clock_i); #1;
      n++;
    end
    chk("mid_exp_idx", ex_q.size(), 4);
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    chk_zero("mid_reset");
    repeat (3) @(posedge clock_i);
    #1;
    chk("no_resume", 32'(exp_valid_o | busy_o), 0);
    feed(v_w, 1'b0, '0);
    fin(v_w, 32'h41200000, 32'h40000000, 1'b0, 0, 1'b0, 1'b1);
    feed(v_nom, 1'b1, v_w[0]);
    fin(v_nom, 32'h40BEEE67, 32'h40C00000, 1'b0, 0, 1'b1, 1'b0);
    feed_rest(v_w);
    fin(v_w, 32'h41200000, 32'h3FC00000, 1'b0, 0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
